uart_rx: RTL

- UART 8N1 receiver; the counterpart of the team's uart_tx, using the same FREQ/RATE parameterisation.
- Synchronises the asynchronous serial line, detects and qualifies the start bit, and samples each bit at mid-period, LSB first.
- Presents each byte with a one-cycle valid strobe, or a framing-error strobe when the stop bit is bad.
- Sits between the board RX pin and the byte consumer (loopback, FIFO, command parser).

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/uart_rx.sv | 119 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, frame constants and the bit-period
// helper that keeps uart_tx and uart_rx timing identical.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_START     = 3'd1;
    localparam state_t ST_DATA      = 3'd2;
    localparam state_t ST_STOP      = 3'd3;
    localparam state_t ST_WAIT_HIGH = 3'd4;

    // Last counter value of one bit period; a bit lasts cnt_max()+1 clocks.
    function automatic int cnt_max(input int freq, input int rate);
        return freq / rate - 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input. RST_VAL chooses the
// level presented while in reset (idle-high lines use 1).
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver: synchronises i_rx, qualifies the start bit at mid-bit,
// samples LSB first and strobes either o_valid or o_frame_err per frame.
module uart_rx
    import uart_pkg::*;
#(
    parameter int FREQ = 50_000_000,
    parameter int RATE = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int CNT_MAX   = cnt_max(FREQ, RATE);
    localparam int HALF      = CNT_MAX / 2;
    localparam int CNT_WIDTH = $clog2(CNT_MAX + 1);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(CNT_MAX);
    localparam logic [CNT_WIDTH-1:0] CNT_MID  = CNT_WIDTH'(HALF);
    localparam logic [2:0]           BIT_LAST = 3'(DATA_BITS - 1);

    if (CNT_MAX < 3) begin : g_cnt_check
        $error("uart_rx: FREQ/RATE gives CNT_MAX below 3");
    end
    if (STOP_BITS != 1) begin : g_stop_check
        $error("uart_rx: only one stop bit is supported");
    end

    logic                 rx_s;
    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [7:0]           shreg_q, shreg_d;
    logic [7:0]           data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 bit_end;

    sync_2ff #(.RST_VAL(1'b1)) u_sync_rx (
        .clk (clk),
        .rst (rst),
        .d   (i_rx),
        .q   (rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (!rx_s) state_d = ST_START;
            ST_START:     if (cnt_q == CNT_MID) state_d = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:      if (bit_end && bit_q == BIT_LAST) state_d = ST_STOP;
            ST_STOP:      if (bit_end) state_d = rx_s ? ST_IDLE : ST_WAIT_HIGH;
            ST_WAIT_HIGH: if (rx_s) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q + CNT_WIDTH'(1);
        bit_d   = bit_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        // Counter restarts on every transition so START's half-period lands mid-bit
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (bit_end && (state_q == ST_DATA || state_q == ST_STOP)) begin
            cnt_d = '0;
        end
        if (state_q == ST_START && state_d == ST_DATA) begin
            bit_d = '0;
        end
        if (state_q == ST_DATA && bit_end) begin
            shreg_d = {rx_s, shreg_q[7:1]};
            bit_d   = bit_q + 3'd1;
        end
        if (state_q == ST_STOP && bit_end) begin
            if (rx_s) begin
                valid_d = 1'b1;
                data_d  = shreg_q;
            end else begin
                ferr_d  = 1'b1;
            end
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;
    assign o_busy      = (state_q != ST_IDLE);

endmodule
